// File: rtl/cdc_sched_pkg.sv
// Shared types and the round-robin search used by the pulse-channel scheduler.
package cdc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_e;

   localparam int MAX_REQ = 16;

   // First set bit at or above ptr, wrapping at n; -1 when nothing is set.
   function automatic int rr_find(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
      int idx;
      int res;
      res = -1;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if ((i < n) && (res < 0) && (idx < MAX_REQ) && req[idx]) res = idx;
      end
      return res;
   endfunction

endpackage

// File: rtl/cdc_pulse_sched_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus pointer in, one-hot grant and index out.
module rr_arbiter
   import cdc_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TAG_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TAG_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [TAG_W-1:0] idx,
   output logic             vld
);

   logic [MAX_REQ-1:0] req_ext;
   int                 g;

   always_comb begin
      req_ext             = '0;
      req_ext[N_REQ-1:0]  = req;
      g                   = rr_find(req_ext, int'(ptr), N_REQ);
      vld                 = (g >= 0);
      idx                 = '0;
      gnt                 = '0;
      if (g >= 0) begin
         idx      = TAG_W'(g);
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cdc_pulse_sched.sv
// Shares one fast-to-slow pulse synchronizer among N_REQ requesters; launches one
// pulse at a time and holds the tag until the synchronizer's busy flag drops.
module cdc_pulse_sched
   import cdc_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TAG_W       = $clog2(N_REQ),
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] pend_o,
   output logic [N_REQ-1:0] done_o,
   output logic [N_REQ-1:0] drop_o,
   output logic             cdc_pulse_o,
   output logic [TAG_W-1:0] cdc_tag_o,
   input  logic             cdc_busy_i,
   output logic             idle_o,
   output logic             timeout_o
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   state_e           state;
   logic [N_REQ-1:0] pend;
   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] tag;
   logic [CNT_W-1:0] wait_cnt;
   logic             pulse;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] drop;
   logic             idle;
   logic             timeout;

   logic [N_REQ-1:0] arb_gnt;
   logic [TAG_W-1:0] arb_idx;
   logic             arb_vld;
   logic             grant_go;
   logic             to_hit;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] tag_1h;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_arb (
      .req (pend),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .vld (arb_vld)
   );

   // A stale busy from an aborted transfer blocks new grants until it clears.
   always_comb begin
      grant_go = (state == ST_IDLE) && arb_vld && !cdc_busy_i;
      clr      = grant_go ? arb_gnt : '0;
      to_hit   = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
      tag_1h      = '0;
      tag_1h[tag] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         pend     <= '0;
         rr_ptr   <= '0;
         tag      <= '0;
         wait_cnt <= '0;
         pulse    <= 1'b0;
         done     <= '0;
         drop     <= '0;
         idle     <= 1'b1;
         timeout  <= 1'b0;
      end else begin
         pulse <= 1'b0;
         done  <= '0;
         // A request coinciding with its own launch re-arms the flag without a drop.
         drop  <= req_i & pend & ~clr;
         pend  <= (pend & ~clr) | req_i;
         case (state)
            ST_IDLE: begin
               if (grant_go) begin
                  tag    <= arb_idx;
                  rr_ptr <= (arb_idx == TAG_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  pulse  <= 1'b1;
                  idle   <= 1'b0;
                  state  <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!cdc_busy_i) begin
                  done     <= tag_1h;
                  wait_cnt <= '0;
                  idle     <= 1'b1;
                  state    <= ST_IDLE;
               end else if (to_hit) begin
                  timeout  <= 1'b1;
                  wait_cnt <= '0;
                  idle     <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               wait_cnt <= '0;
               idle     <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign pend_o      = pend;
   assign done_o      = done;
   assign drop_o      = drop;
   assign cdc_pulse_o = pulse;
   assign cdc_tag_o   = tag;
   assign idle_o      = idle;
   assign timeout_o   = timeout;

endmodule

// File: tb/tb_cdc_pulse_sched.sv
// Randomized and directed bench for cdc_pulse_sched against a transaction-level reference model.
module tb_cdc_pulse_sched;

   localparam int N  = 4;
   localparam int TW = 2;
   localparam int TO = 8;

   logic          clk;
   logic          rst_i;
   logic [N-1:0]  req_i;
   logic [N-1:0]  pend_o;
   logic [N-1:0]  done_o;
   logic [N-1:0]  drop_o;
   logic          cdc_pulse_o;
   logic [TW-1:0] cdc_tag_o;
   logic          cdc_busy_i;
   logic          idle_o;
   logic          timeout_o;

   cdc_pulse_sched #(
      .N_REQ       (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .pend_o      (pend_o),
      .done_o      (done_o),
      .drop_o      (drop_o),
      .cdc_pulse_o (cdc_pulse_o),
      .cdc_tag_o   (cdc_tag_o),
      .cdc_busy_i  (cdc_busy_i),
      .idle_o      (idle_o),
      .timeout_o   (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errs   = 0;

   // reference model state
   logic [N-1:0]  e_pend, e_done, e_drop;
   logic          e_pulse, e_idle, e_to;
   logic [TW-1:0] e_tag;
   int            m_rr, m_wn;
   bit            m_launch, m_fly;

   // synchronizer busy model
   int  bcnt = 0;
   int  bhold = 6;
   bit  noise_en = 0;

   // observation counters
   int  launch_q[$];
   int  drop1_n = 0;
   int  done_n  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic rs, input logic b);
      int clr;
      if (rs) begin
         e_pend = '0; e_done = '0; e_drop = '0; e_pulse = 0; e_idle = 1; e_to = 0;
         e_tag = '0; m_rr = 0; m_wn = 0; m_launch = 0; m_fly = 0;
         return;
      end
      clr = -1;
      e_done = '0; e_drop = '0; e_pulse = 0;
      if (m_launch) begin
         m_launch = 0; m_fly = 1; m_wn = 0;
      end else if (m_fly) begin
         m_wn++;
         if (!b) begin
            e_done[e_tag] = 1'b1; m_fly = 0;
         end else if (TO != 0 && m_wn == TO) begin
            e_to = 1; m_fly = 0;
         end
      end else if (e_pend != 0 && !b) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (e_pend[k]) begin clr = k; break; end
         end
         e_tag = TW'(clr);
         m_rr = (clr + 1) % N;
         m_launch = 1;
         e_pulse = 1;
      end
      for (int k = 0; k < N; k++) begin
         if (r[k]) begin
            if (e_pend[k] && k != clr) e_drop[k] = 1'b1;
            e_pend[k] = 1'b1;
         end else if (k == clr) begin
            e_pend[k] = 1'b0;
         end
      end
      e_idle = !m_launch && !m_fly;
   endtask

   task automatic compare_all();
      chk("pend",    32'(pend_o),      32'(e_pend));
      chk("done",    32'(done_o),      32'(e_done));
      chk("drop",    32'(drop_o),      32'(e_drop));
      chk("pulse",   32'(cdc_pulse_o), 32'(e_pulse));
      chk("idle",    32'(idle_o),      32'(e_idle));
      chk("timeout", 32'(timeout_o),   32'(e_to));
      if (e_pulse || m_fly) chk("tag", 32'(cdc_tag_o), 32'(e_tag));
      if (cdc_pulse_o) launch_q.push_back(int'(cdc_tag_o));
      if (drop_o[1]) drop1_n++;
      done_n += $countones(done_o);
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic rs);
      logic b;
      if (rs) bcnt = 0;
      else if (cdc_pulse_o) bcnt = bhold;
      else if (bcnt > 0) bcnt--;
      b = !rs && ((bcnt > 0) || (noise_en && $urandom_range(0, 7) == 0));
      req_i = r; rst_i = rs; cdc_busy_i = b;
      model_step(r, rs, b);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      cycle('0, 1'b1);
      cycle('0, 1'b1);
      launch_q.delete();
      drop1_n = 0;
      done_n  = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle('0, 1'b0);
   endtask

   initial begin
      rst_i = 1'b1; req_i = '0; cdc_busy_i = 1'b0;
      model_step('0, 1'b1, 1'b0);

      // reset state
      do_reset();
      chk("rst_idle",  32'(idle_o),      32'd1);
      chk("rst_pend",  32'(pend_o),      32'd0);
      chk("rst_pulse", 32'(cdc_pulse_o), 32'd0);

      // single event: pulse two cycles after the request, tag 2
      bhold = 6;
      cycle(4'b0100, 1'b0);
      chk("single_pend", 32'(pend_o), 32'h4);
      cycle('0, 1'b0);
      chk("single_pulse", 32'(cdc_pulse_o), 32'd1);
      chk("single_tag",   32'(cdc_tag_o),   32'd2);
      idle_cycles(12);
      chk("single_done_n", 32'(done_n), 32'd1);

      // round-robin from a fresh pointer
      do_reset();
      bhold = 3;
      cycle(4'b1111, 1'b0);
      idle_cycles(30);
      chk("rr_n", 32'(launch_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < launch_q.size()) chk("rr_order", 32'(launch_q[i]), 32'(i));
      chk("rr_done_n", 32'(done_n), 32'd4);

      // overflow: requester 1 pulsed three times while 0 is in flight
      do_reset();
      bhold = 12;
      cycle(4'b0001, 1'b0);
      idle_cycles(2);
      cycle(4'b0010, 1'b0);
      cycle('0, 1'b0);
      cycle(4'b0010, 1'b0);
      cycle('0, 1'b0);
      cycle(4'b0010, 1'b0);
      idle_cycles(40);
      chk("ovf_drop_n", 32'(drop1_n), 32'd2);
      chk("ovf_launch_n", 32'(launch_q.size()), 32'd2);
      if (launch_q.size() == 2) chk("ovf_tag1", 32'(launch_q[1]), 32'd1);

      // same-cycle relaunch of requester 0
      do_reset();
      bhold = 2;
      cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b0);
      chk("relaunch_pend", 32'(pend_o), 32'h1);
      chk("relaunch_drop", 32'(drop_o), 32'h0);
      idle_cycles(20);
      chk("relaunch_n", 32'(launch_q.size()), 32'd2);

      // timeout with busy held, then release
      do_reset();
      bhold = 1000;
      cycle(4'b0001, 1'b0);
      cycle(4'b0010, 1'b0);
      idle_cycles(14);
      chk("to_flag",   32'(timeout_o), 32'd1);
      chk("to_idle",   32'(idle_o),    32'd1);
      chk("to_pend1",  32'(pend_o[1]), 32'd1);
      chk("to_done_n", 32'(done_n),    32'd0);
      bcnt = 0; bhold = 3;
      cycle(4'b0100, 1'b0);
      cycle('0, 1'b0);
      cycle('0, 1'b0);
      chk("to_next_tag", 32'(cdc_tag_o), 32'd1);

      // reset while waiting, with another request pending
      bhold = 1000;
      idle_cycles(2);
      cycle('0, 1'b1);
      chk("mid_rst_pend",  32'(pend_o),      32'd0);
      chk("mid_rst_idle",  32'(idle_o),      32'd1);
      chk("mid_rst_to",    32'(timeout_o),   32'd0);
      chk("mid_rst_pulse", 32'(cdc_pulse_o), 32'd0);

      // randomized traffic with stale-busy noise and occasional resets
      noise_en = 1;
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] r;
         bhold = $urandom_range(0, 11);
         r = N'($urandom & $urandom & $urandom);
         cycle(r, ($urandom_range(0, 399) == 0));
      end
      noise_en = 0;
      bhold = 1;
      idle_cycles(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end

endmodule
